fa_bist: RTL

Sequential built-in self-test engine for the `fa` full-adder cell. It drives `fa` inputs A, B and Cin, and reads back its S and Cout.
- Steps all 8 input combinations once per run.
- Compares each response against a golden model.
- Reports pass/fail, a saturating error count and the first failing vector.
- Sits beside an `fa` instance in lab top levels, so the cell can be checked in hardware without a simulator.

---
 rtl/fa_bist_pkg.sv | 8 +
 rtl/fa_bist_if.sv | 6 +
 rtl/fa_bist.sv | 83 ++++++++
 3 files changed

// File: rtl/fa_bist_pkg.sv
// fa_bist_pkg: shared states, vector count and golden full-adder model for fa_bist.
package fa_bist_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
    localparam int NUM_VECTORS = 8;
    function automatic logic [1:0] fa_expected(input logic a, input logic b, input logic cin);
        return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endfunction
endpackage

// File: rtl/fa_bist_if.sv
// fa_bist_if: stimulus/response wires between the BIST engine and the fa cell under test.
interface fa_bist_if;
    logic A, B, Cin, S, Cout;
    modport master(output A, B, Cin, input S, Cout);
    modport slave(input A, B, Cin, output S, Cout);
endinterface

// File: rtl/fa_bist.sv
// fa_bist: walks all 8 full-adder input vectors, compares against the golden model, reports results.
module fa_bist import fa_bist_pkg::*; #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    fa_bist_if.master        dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       fail_vec,
    output logic             fail_valid
);
    localparam int CW = SETTLE_CYCLES < 2 ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SC = CW'(SETTLE_CYCLES);
    state_t state_q, state_d;
    logic [2:0] idx_q, idx_d, fvec_q, fvec_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic fval_q, fval_d, mism;
    // case-inequality so X/Z responses count as failures
    assign mism = {dut.Cout, dut.S} !== fa_expected(idx_q[2], idx_q[1], idx_q[0]);
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            idx_q <= '0;
            cnt_q <= '0;
            err_q <= '0;
            fvec_q <= '0;
            fval_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            fvec_q <= fvec_d;
            fval_q <= fval_d;
        end
    end
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        err_d = err_q;
        fvec_d = fvec_q;
        fval_d = fval_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = SETTLE;
                idx_d = '0;
                cnt_d = SC;
                err_d = '0;
                fvec_d = '0;
                fval_d = 1'b0;
            end
            SETTLE: if (cnt_q == CW'(1)) state_d = CHECK; else cnt_d = cnt_q - CW'(1);
            CHECK: begin
                if (mism) begin
                    err_d = &err_q ? err_q : err_q + CNT_W'(1);
                    fvec_d = fval_q ? fvec_q : idx_q;
                    fval_d = 1'b1;
                end
                if (idx_q == 3'(NUM_VECTORS - 1)) state_d = DONE;
                else begin
                    idx_d = idx_q + 3'd1;
                    cnt_d = SC;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign {dut.A, dut.B, dut.Cin} = idx_q;
    assign busy = state_q == SETTLE || state_q == CHECK;
    assign done = state_q == DONE;
    assign pass = done && err_q == '0;
    assign err_count = err_q;
    assign fail_vec = fvec_q;
    assign fail_valid = fval_q;
endmodule
